mips_mem_arbiter: RTL and testbench

- Arbitrates the single shared 1024x32 word memory between the instruction-fetch port (IF, read-only) and the data port (MEM stage, load/store).
- One transaction is outstanding at a time.
- The data port has priority, with a starvation guard for fetch.
- A watchdog terminates transactions the memory never acknowledges.
- Sits between the pipeline stages and the memory macro/model.

---
 rtl/mips_mem_arbiter_if.sv | 38 +++
 rtl/mips_mem_arbiter.sv | 107 ++++++++++
 tb/tb_mips_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: bus bundle between pipeline requesters, memory and the arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mips_mem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              halt;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              busy;
   logic              err;
   modport slave (
      input  halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy, err
   );
   modport master (
      output halt, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy, err
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory between fetch and data ports, data first,
// with a fetch starvation guard and an ack watchdog; all outputs registered.
module mips_mem_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input logic                clock,
   input logic                reset_n,
   mips_mem_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

   state_t            state_q;
   logic [SW-1:0]     starve_q;
   logic [WW-1:0]     wdog_q;
   logic              if_gnt_q, if_rvalid_q, dm_gnt_q, dm_rvalid_q;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
   logic              mem_en_q, mem_we_q, err_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              done, dm_win, if_win;
   logic [DATA_W-1:0] ack_data;

   // A timed-out transaction returns zero; stores always return zero.
   assign done     = bus.mem_ack || wdog_q == WD_LAST;
   assign ack_data = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
   assign dm_win   = !bus.halt && bus.dm_req && (!bus.if_req || starve_q < STARVE_MAX);
   assign if_win   = !bus.halt && !dm_win && bus.if_req;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         wdog_q      <= '0;
         if_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_gnt_q    <= 1'b0;
         dm_rvalid_q <= 1'b0;
         dm_rdata_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
      end else begin
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if (state_q == IDLE) begin
            if (!bus.if_req) starve_q <= '0;
            if (dm_win) begin
               dm_gnt_q    <= 1'b1;
               mem_en_q    <= 1'b1;
               mem_we_q    <= bus.dm_we;
               mem_addr_q  <= bus.dm_addr;
               mem_wdata_q <= bus.dm_wdata;
               state_q     <= BUSY_DM;
               if (bus.if_req) starve_q <= starve_q + SW'(1);
            end else if (if_win) begin
               if_gnt_q   <= 1'b1;
               mem_en_q   <= 1'b1;
               mem_we_q   <= 1'b0;
               mem_addr_q <= bus.if_addr;
               starve_q   <= '0;
               state_q    <= BUSY_IF;
            end
         end else if (done) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            wdog_q   <= '0;
            if (!bus.mem_ack) err_q <= 1'b1;
            if (state_q == BUSY_IF) begin
               if_rvalid_q <= 1'b1;
               if_rdata_q  <= ack_data;
            end else begin
               dm_rvalid_q <= 1'b1;
               dm_rdata_q  <= ack_data;
            end
         end else begin
            wdog_q <= wdog_q + WW'(1);
         end
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_gnt    = dm_gnt_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = state_q != IDLE;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed vectors with hand-computed expectations for the arbiter.
module tb_mips_mem_arbiter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   mips_mem_arbiter_if bus ();

   mips_mem_arbiter dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [1:0] order_exp [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                  2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

   initial begin
      bus.halt = 0; bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
      bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 0;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_mem_en", 32'(bus.mem_en), 0);
      check("rst_err", 32'(bus.err), 0);
      check("rst_gnt", 32'({bus.if_gnt, bus.dm_gnt}), 0);
      reset_n = 1;
      tick();

      // single fetch
      bus.if_req = 1; bus.if_addr = 10'h005;
      tick();
      check("if_gnt", 32'(bus.if_gnt), 1);
      check("if_mem", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'({2'b10, 10'h005}));
      check("if_busy", 32'(bus.busy), 1);
      bus.if_req = 0;
      tick();
      check("if_gnt_pulse", 32'(bus.if_gnt), 0);
      check("if_mem_hold", 32'({bus.mem_en, bus.mem_addr}), 32'({1'b1, 10'h005}));
      bus.mem_ack = 1; bus.mem_rdata = 32'h0022_1800;
      tick();
      bus.mem_ack = 0;
      check("if_rvalid", 32'(bus.if_rvalid), 1);
      check("if_rdata", bus.if_rdata, 32'h0022_1800);
      check("if_done", 32'({bus.busy, bus.mem_en}), 0);
      tick();
      check("if_rvalid_pulse", 32'(bus.if_rvalid), 0);

      // store
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 10'h3FF; bus.dm_wdata = 32'hDEAD_BEEF;
      tick();
      check("st_gnt", 32'(bus.dm_gnt), 1);
      check("st_mem", 32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'({2'b11, 10'h3FF}));
      check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      bus.dm_req = 0;
      bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
      tick();
      bus.mem_ack = 0;
      check("st_rvalid", 32'(bus.dm_rvalid), 1);
      check("st_rdata", bus.dm_rdata, 0);
      tick();

      // contention with starvation guard
      bus.dm_we = 0; bus.dm_addr = 10'h100; bus.if_addr = 10'h200;
      bus.dm_req = 1; bus.if_req = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("arb_order%0d", i), 32'({bus.if_gnt, bus.dm_gnt}), 32'(order_exp[i]));
         bus.mem_ack = 1; bus.mem_rdata = 32'(i);
         tick();
         bus.mem_ack = 0;
         check($sformatf("arb_rv%0d", i), 32'({bus.if_rvalid, bus.dm_rvalid}), 32'(order_exp[i]));
      end
      bus.dm_req = 0; bus.if_req = 0;
      tick();

      // timeout
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'h010; bus.mem_rdata = 32'hAAAA_5555;
      tick();
      check("to_gnt", 32'(bus.dm_gnt), 1);
      bus.dm_req = 0;
      for (int i = 0; i < 15; i++) tick();
      check("to_wait", 32'({bus.busy, bus.dm_rvalid, bus.err}), 32'b100);
      tick();
      check("to_rvalid", 32'(bus.dm_rvalid), 1);
      check("to_rdata", bus.dm_rdata, 0);
      check("to_err", 32'({bus.err, bus.mem_en, bus.busy}), 32'b100);
      bus.mem_ack = 1;
      tick();
      bus.mem_ack = 0;
      check("late_ack", 32'({bus.if_rvalid, bus.dm_rvalid, bus.busy, bus.mem_en}), 0);
      check("err_sticky", 32'(bus.err), 1);
      bus.if_req = 1; bus.if_addr = 10'h020;
      tick();
      check("post_to_gnt", 32'({bus.if_gnt, bus.mem_addr}), 32'({1'b1, 10'h020}));
      bus.if_req = 0;
      bus.mem_ack = 1; bus.mem_rdata = 32'h0BAD_F00D;
      tick();
      bus.mem_ack = 0;
      check("post_to_rdata", bus.if_rdata, 32'h0BAD_F00D);
      check("post_to_rvalid", 32'(bus.if_rvalid), 1);
      tick();

      // halt
      bus.if_req = 1; bus.if_addr = 10'h007;
      tick();
      check("h_if_gnt", 32'(bus.if_gnt), 1);
      bus.halt = 1; bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 10'h044;
      bus.mem_ack = 1; bus.mem_rdata = 32'h1111_2222;
      tick();
      bus.mem_ack = 0;
      check("h_complete", bus.if_rdata, 32'h1111_2222);
      check("h_rvalid", 32'(bus.if_rvalid), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("h_nogrant%0d", i), 32'({bus.if_gnt, bus.dm_gnt, bus.busy}), 0);
      end
      bus.halt = 0;
      tick();
      check("h_dm_first", 32'({bus.if_gnt, bus.dm_gnt, bus.mem_addr}), 32'({2'b01, 10'h044}));
      bus.dm_req = 0;
      bus.mem_ack = 1; bus.mem_rdata = 32'h3333_4444;
      tick();
      bus.mem_ack = 0;
      check("h_dm_rdata", bus.dm_rdata, 32'h3333_4444);
      tick();
      check("h_if_next", 32'({bus.if_gnt, bus.dm_gnt}), 32'b10);
      bus.if_req = 0;
      bus.mem_ack = 1;
      tick();
      bus.mem_ack = 0;
      tick();

      // reset mid-transaction
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 10'h055; bus.dm_wdata = 32'hCAFE_0001;
      tick();
      check("rm_gnt", 32'(bus.dm_gnt), 1);
      bus.dm_req = 0;
      tick();
      check("rm_busy", 32'(bus.busy), 1);
      reset_n = 0;
      bus.mem_ack = 1;
      #1;
      check("rm_async", 32'({bus.busy, bus.mem_en, bus.mem_we, bus.err}), 0);
      tick();
      check("rm_no_rvalid", 32'({bus.dm_rvalid, bus.if_rvalid, bus.busy}), 0);
      check("rm_mem_addr", 32'(bus.mem_addr), 0);
      bus.mem_ack = 0;
      reset_n = 1;
      tick();
      check("rm_idle", 32'({bus.dm_rvalid, bus.busy, bus.dm_gnt, bus.if_gnt}), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
